tmr_recovery_ctrl: RTL and testbench

TMR_RECOVERY_CTRL -- requirements
Module: tmr_recovery_ctrl

---
 rtl/eros_pkg.sv | 19 +
 rtl/tmr_recovery_ctrl.sv | 133 +++++++++++++
 tb/tb_tmr_recovery_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/eros_pkg.sv
// Shared types and widths for the TMR recovery controller.
package eros_pkg;

    localparam int CNT_W   = 8;
    localparam int STATE_W = 3;
    localparam int TMR_W   = 16;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [STATE_W-1:0] {
        ST_DISABLED = 3'd0,
        ST_VOTING   = 3'd1,
        ST_HALT     = 3'd2,
        ST_SYNC     = 3'd3,
        ST_RESUME   = 3'd4,
        ST_FAULT    = 3'd5
    } state_e;

endpackage

// File: rtl/tmr_recovery_ctrl.sv
// TMR recovery sequencer: on a voter mismatch, halt all harts, resync context, resume; too many retries -> FAULT.
// Optional HALT/SYNC watchdog is compiled in with TMR_RECOVERY_TIMEOUT_EN.
module tmr_recovery_ctrl
    import eros_pkg::*;
#(
    parameter int NHARTS         = 3,
    parameter int MAX_RETRY      = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              tmr_mode_i,
    input  logic              error_i,
    input  logic [NHARTS-1:0] error_id_i,
    output logic              voter_enable_o,
    output logic [NHARTS-1:0] halt_req_o,
    input  logic [NHARTS-1:0] halted_i,
    output logic              sync_start_o,
    input  logic              sync_done_i,
    output logic              resume_o,
    input  logic              clear_i,
    output logic [NHARTS-1:0] faulty_id_o,
    output logic [CNT_W-1:0]  error_cnt_o,
    output logic              fault_o,
    output logic [STATE_W-1:0] state_o
);

    if (MAX_RETRY < 1 || MAX_RETRY > 255) begin : g_bad_retry
        $error("MAX_RETRY must be in 1..255");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end

    localparam logic [CNT_W-1:0] RETRY_LIM = CNT_W'(MAX_RETRY);

    state_e             state_q, state_d;
    logic [NHARTS-1:0]  faulty_id_q, faulty_id_d;
    logic [CNT_W-1:0]   error_cnt_q, error_cnt_d;
    logic [CNT_W-1:0]   cnt_base;
    logic               sync_start_q, sync_start_d;
    logic               in_hold;

`ifdef TMR_RECOVERY_TIMEOUT_EN
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             timeout;
`endif

    assign in_hold = (state_q == ST_HALT) || (state_q == ST_SYNC);
    // A clear in the same cycle as an error counts that error as the first one.
    assign cnt_base = clear_i ? '0 : error_cnt_q;

    always_comb begin
        state_d      = state_q;
        faulty_id_d  = faulty_id_q;
        error_cnt_d  = error_cnt_q;
        if (clear_i) begin
            faulty_id_d = '0;
            error_cnt_d = '0;
        end
`ifdef TMR_RECOVERY_TIMEOUT_EN
        timer_d = in_hold ? timer_q + 1'b1 : timer_q;
        timeout = in_hold && (timer_q == TMO_LAST);
`endif
        case (state_q)
            ST_DISABLED: if (tmr_mode_i) state_d = ST_VOTING;
            ST_VOTING: begin
                if (error_i) begin
                    faulty_id_d = error_id_i;
`ifdef TMR_RECOVERY_TIMEOUT_EN
                    timer_d = '0;
`endif
                    if (cnt_base >= RETRY_LIM) begin
                        state_d = ST_FAULT;
                    end else begin
                        state_d     = ST_HALT;
                        error_cnt_d = (cnt_base == CNT_MAX) ? CNT_MAX : cnt_base + 1'b1;
                    end
                end else if (!tmr_mode_i) begin
                    state_d = ST_DISABLED;
                end
            end
            ST_HALT: begin
`ifdef TMR_RECOVERY_TIMEOUT_EN
                if (timeout) state_d = ST_FAULT; else
`endif
                if (&halted_i) state_d = ST_SYNC;
            end
            ST_SYNC: begin
`ifdef TMR_RECOVERY_TIMEOUT_EN
                if (timeout) state_d = ST_FAULT; else
`endif
                if (sync_done_i) state_d = ST_RESUME;
            end
            ST_RESUME:   state_d = ST_VOTING;
            ST_FAULT:    if (clear_i) state_d = ST_DISABLED;
            default:     state_d = ST_DISABLED;
        endcase
        sync_start_d = (state_d == ST_SYNC) && (state_q != ST_SYNC);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= ST_DISABLED;
            faulty_id_q  <= '0;
            error_cnt_q  <= '0;
            sync_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            faulty_id_q  <= faulty_id_d;
            error_cnt_q  <= error_cnt_d;
            sync_start_q <= sync_start_d;
        end
    end

`ifdef TMR_RECOVERY_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni) timer_q <= '0;
        else         timer_q <= timer_d;
    end
`endif

    assign voter_enable_o = (state_q == ST_VOTING);
    assign halt_req_o     = {NHARTS{in_hold || (state_q == ST_FAULT)}};
    assign sync_start_o   = sync_start_q;
    assign resume_o       = (state_q == ST_RESUME);
    assign fault_o        = (state_q == ST_FAULT);
    assign faulty_id_o    = faulty_id_q;
    assign error_cnt_o    = error_cnt_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_tmr_recovery_ctrl.sv
// Bench for tmr_recovery_ctrl: vector table, directed corner sequences, then random stimulus vs a reference model.
`timescale 1ns/1ps
module tb_tmr_recovery_ctrl;

    localparam int NH = 3;
    localparam int MR = 3;
    localparam int TO = 16;
    localparam int S_DIS = 0, S_VOT = 1, S_HLT = 2, S_SYN = 3, S_RES = 4, S_FLT = 5;
`ifdef TMR_RECOVERY_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0, tmr_mode = 1'b0, err = 1'b0, sync_done = 1'b0, clear = 1'b0;
    logic [2:0] err_id = '0, halted = '0;
    logic       ven, sync_start, resume, fault;
    logic [2:0] halt_req, fid, state;
    logic [7:0] cnt;

    int total = 0;
    int bad   = 0;

    int m_st = S_DIS, m_cnt = 0, m_fid = 0, m_tmr = 0;
    bit m_pulse = 1'b0;

    tmr_recovery_ctrl #(.NHARTS(NH), .MAX_RETRY(MR), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n), .tmr_mode_i(tmr_mode),
        .error_i(err), .error_id_i(err_id), .voter_enable_o(ven),
        .halt_req_o(halt_req), .halted_i(halted),
        .sync_start_o(sync_start), .sync_done_i(sync_done),
        .resume_o(resume), .clear_i(clear), .faulty_id_o(fid),
        .error_cnt_o(cnt), .fault_o(fault), .state_o(state)
    );

    always #5 clk = ~clk;

    // Reference model: applies the inputs present before the coming edge.
    task automatic model_step();
        bit hold;
        m_pulse = 1'b0;
        if (!rst_n) begin
            m_st = S_DIS; m_cnt = 0; m_fid = 0; m_tmr = 0;
            return;
        end
        if (clear) begin m_cnt = 0; m_fid = 0; end
        hold = (m_st == S_HLT) || (m_st == S_SYN);
        if (hold) m_tmr++;
        if (m_st == S_DIS) begin
            if (tmr_mode) m_st = S_VOT;
        end else if (m_st == S_VOT) begin
            if (err) begin
                m_fid = err_id;
                m_tmr = 0;
                if (m_cnt >= MR) m_st = S_FLT;
                else begin
                    m_st  = S_HLT;
                    m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
                end
            end else if (!tmr_mode) m_st = S_DIS;
        end else if (hold) begin
            if (TMO_ON && m_tmr >= TO) m_st = S_FLT;
            else if (m_st == S_HLT && halted == 3'b111) begin m_st = S_SYN; m_pulse = 1'b1; end
            else if (m_st == S_SYN && sync_done) m_st = S_RES;
        end else if (m_st == S_RES) m_st = S_VOT;
        else if (m_st == S_FLT && clear) m_st = S_DIS;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        bit hold;
        hold = (m_st == S_HLT) || (m_st == S_SYN) || (m_st == S_FLT);
        chk({tag, ".state"}, int'(state), m_st);
        chk({tag, ".cnt"}, int'(cnt), m_cnt);
        chk({tag, ".fid"}, int'(fid), m_fid);
        chk({tag, ".ven"}, int'(ven), int'(m_st == S_VOT));
        chk({tag, ".halt"}, int'(halt_req), hold ? 7 : 0);
        chk({tag, ".sync_start"}, int'(sync_start), int'(m_pulse));
        chk({tag, ".resume"}, int'(resume), int'(m_st == S_RES));
        chk({tag, ".fault"}, int'(fault), int'(m_st == S_FLT));
    endtask

    task automatic idle_in();
        rst_n = 1'b1; tmr_mode = 1'b1; err = 1'b0; err_id = '0;
        halted = '0; sync_done = 1'b0; clear = 1'b0;
    endtask

    task automatic do_reset();
        idle_in();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic recover(input logic [2:0] id);
        err = 1'b1; err_id = id; step();
        err = 1'b0; halted = 3'b111; step();
        halted = '0; sync_done = 1'b1; step();
        sync_done = 1'b0; step();
    endtask

    typedef struct {
        logic       rst_n, mode, err;
        logic [2:0] id, halted;
        logic       sdone, clr;
        int         st, cnt, fid, halt, ss, res;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic [2:0] one_hot;
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, S_DIS, 0, 0, 0, 0, 0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0, S_DIS, 0, 0, 0, 0, 0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, S_VOT, 0, 0, 0, 0, 0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0, S_VOT, 0, 0, 0, 0, 0};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 3'b010, 3'b000, 1'b0, 1'b0, S_HLT, 1, 2, 7, 0, 0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 3'b000, 3'b011, 1'b0, 1'b0, S_HLT, 1, 2, 7, 0, 0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 3'b000, 3'b111, 1'b0, 1'b0, S_SYN, 1, 2, 7, 1, 0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 3'b000, 3'b111, 1'b0, 1'b0, S_SYN, 1, 2, 7, 0, 0};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0, S_RES, 1, 2, 0, 0, 1};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0, S_VOT, 1, 2, 0, 0, 0};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 3'b100, 3'b000, 1'b1, 1'b0, S_HLT, 2, 4, 7, 0, 0};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 3'b001, 3'b000, 1'b0, 1'b0, S_HLT, 2, 4, 7, 0, 0};

        for (int i = 0; i < 12; i++) begin
            string t;
            rst_n = tbl[i].rst_n; tmr_mode = tbl[i].mode; err = tbl[i].err;
            err_id = tbl[i].id; halted = tbl[i].halted;
            sync_done = tbl[i].sdone; clear = tbl[i].clr;
            step();
            t = $sformatf("vec%0d", i);
            chk({t, ".state"}, int'(state), tbl[i].st);
            chk({t, ".cnt"}, int'(cnt), tbl[i].cnt);
            chk({t, ".fid"}, int'(fid), tbl[i].fid);
            chk({t, ".halt"}, int'(halt_req), tbl[i].halt);
            chk({t, ".sync_start"}, int'(sync_start), tbl[i].ss);
            chk({t, ".resume"}, int'(resume), tbl[i].res);
            chk({t, ".ven"}, int'(ven), int'(tbl[i].st == S_VOT));
            chk({t, ".fault"}, int'(fault), int'(tbl[i].st == S_FLT));
        end

        // Retry exhaustion: the fourth error lands in FAULT with the count held at 3.
        do_reset();
        step();
        chk("retry.start_state", int'(state), S_VOT);
        one_hot = 3'b001;
        for (int i = 1; i <= 3; i++) begin
            recover(one_hot);
            one_hot = one_hot << 1;
            chk($sformatf("retry%0d.cnt", i), int'(cnt), i);
            chk($sformatf("retry%0d.state", i), int'(state), S_VOT);
        end
        err = 1'b1; err_id = 3'b110; step(); err = 1'b0;
        chk("retry4.state", int'(state), S_FLT);
        chk("retry4.fault", int'(fault), 1);
        chk("retry4.cnt", int'(cnt), 3);
        chk("retry4.halt", int'(halt_req), 7);
        step();
        chk("fault_hold.state", int'(state), S_FLT);
        clear = 1'b1; step(); clear = 1'b0;
        chk("clear.state", int'(state), S_DIS);
        chk("clear.cnt", int'(cnt), 0);
        chk("clear.fid", int'(fid), 0);
        chk("clear.fault", int'(fault), 0);

        // Clear and error together in VOTING: count restarts at one.
        step();
        recover(3'b001);
        recover(3'b010);
        chk("clrerr.pre_cnt", int'(cnt), 2);
        err = 1'b1; clear = 1'b1; err_id = 3'b100; step();
        err = 1'b0; clear = 1'b0;
        chk("clrerr.state", int'(state), S_HLT);
        chk("clrerr.cnt", int'(cnt), 1);
        chk("clrerr.fid", int'(fid), 4);

        // Reset taken mid-SYNC.
        halted = 3'b111; step();
        chk("rstsync.pre_state", int'(state), S_SYN);
        rst_n = 1'b0; halted = '0; step();
        chk("rstsync.state", int'(state), S_DIS);
        chk("rstsync.outs", int'({ven, halt_req, sync_start, resume, fault}), 0);
        chk("rstsync.cnt", int'(cnt), 0);
        chk("rstsync.fid", int'(fid), 0);

        // Watchdog: one hart never acknowledges the halt.
        idle_in(); step();
        err = 1'b1; err_id = 3'b100; step(); err = 1'b0;
        halted = 3'b011;
        chk("tmo.entry", int'(state), S_HLT);
`ifdef TMR_RECOVERY_TIMEOUT_EN
        repeat (TO - 1) step();
        chk("tmo.before", int'(state), S_HLT);
        step();
        chk("tmo.fault", int'(state), S_FLT);
        chk("tmo.fault_o", int'(fault), 1);
`else
        repeat (1000) step();
        chk("tmo.no_timer", int'(state), S_HLT);
`endif

        // Random stimulus against the reference model.
        do_reset();
        check_model("rand_rst");
        for (int c = 0; c < 3000; c++) begin
            rst_n     = ($urandom_range(0, 149) != 0);
            tmr_mode  = ($urandom_range(0, 7) != 0);
            err       = ($urandom_range(0, 5) == 0);
            err_id    = 3'($urandom_range(0, 7));
            halted    = ($urandom_range(0, 1) == 1) ? 3'b111 : 3'($urandom_range(0, 7));
            sync_done = ($urandom_range(0, 2) == 0);
            clear     = ($urandom_range(0, 24) == 0);
            step();
            check_model($sformatf("rand%0d", c));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
